// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU <-> fabric I/O pass-through block.
package cpu_io_pkg;

  localparam int LANE_W_DEF = 4;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    OP_EMPTY = 1'b0,
    OP_HELD  = 1'b1
  } op_state_e;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cpu_io_pass_n_if.sv
// Operand, fabric and result handshake bundle; slave is the pass block, master the CPU/fabric side.
interface cpu_io_pass_n_if import cpu_io_pkg::*; #(
  parameter int NUM_OP    = 2,
  parameter int NUM_RES   = 3,
  parameter int LANE_W    = LANE_W_DEF,
  parameter int RES_DEPTH = 4
);
  localparam int CNT_W = $clog2(RES_DEPTH+1);

  logic [NUM_OP*LANE_W-1:0]  op_data;
  logic                      op_valid;
  logic                      op_ready;
  logic [NUM_OP*LANE_W-1:0]  fab_op;
  logic                      fab_op_vld;
  logic                      fab_op_ack;
  logic [NUM_RES*LANE_W-1:0] fab_res;
  logic                      fab_res_push;
  logic [NUM_RES*LANE_W-1:0] res_data;
  logic                      res_valid;
  logic                      res_ready;
  logic [CNT_W-1:0]          res_count;
  logic                      res_full;

  modport slave (
    input  op_data, op_valid, fab_op_ack, fab_res, fab_res_push, res_ready,
    output op_ready, fab_op, fab_op_vld, res_data, res_valid, res_count, res_full
  );

  modport master (
    output op_data, op_valid, fab_op_ack, fab_res, fab_res_push, res_ready,
    input  op_ready, fab_op, fab_op_vld, res_data, res_valid, res_count, res_full
  );

endinterface

// File: rtl/cpu_io_res_fifo.sv
// Result FIFO: registered head (no fall-through), push-while-full accepted only with a same-cycle pop.
module cpu_io_res_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_req_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_ready_i,
  output logic [W-1:0]               rd_data_o,
  output logic                       rd_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       drop_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid, full, push, pop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = valid & rd_ready_i;
  assign push  = wr_req_i & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the empty-gate on the head keeps registered lanes at zero.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = valid ? mem_q[rd_ptr_q] : '0;
  assign rd_valid_o = valid;
  assign count_o    = count_q;
  assign full_o     = full;
  assign drop_o     = wr_req_i & full & ~pop;

endmodule

// File: rtl/cpu_io_pass_n.sv
// CPU <-> fabric pass block: one-deep operand hold stage plus result FIFO, per-lane registered/bypass select.
// Optional macro CPU_IO_DROP_CNT_EN adds an 8-bit saturating drop_cnt output for rejected result pushes.
module cpu_io_pass_n import cpu_io_pkg::*; #(
  parameter int NUM_OP    = 2,
  parameter int NUM_RES   = 3,
  parameter int LANE_W    = LANE_W_DEF,
  parameter int RES_DEPTH = 4
) (
  input  logic                        UserCLK,
  input  logic                        RESETn,
  input  logic [NUM_OP+NUM_RES-1:0]   ConfigBits,
`ifdef CPU_IO_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]       drop_cnt,
`endif
  cpu_io_pass_n_if.slave              bus
);
  localparam int OP_W  = NUM_OP*LANE_W;
  localparam int RES_W = NUM_RES*LANE_W;
  localparam int CNT_W = $clog2(RES_DEPTH+1);

  // Assert asynchronously, release two UserCLK edges later.
  logic rst_meta_q, rst_sync_q, rst_n;
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end
  assign rst_n = rst_sync_q;

  op_state_e       state_q, state_d;
  logic [OP_W-1:0] hold_q, hold_d;
  logic            op_ready, fab_op_vld;

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OP_EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // ack with a new operand reloads the hold register in place, so there is no bubble.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    op_ready   = 1'b1;
    fab_op_vld = 1'b0;
    case (state_q)
      OP_EMPTY: begin
        if (bus.op_valid) begin
          state_d = OP_HELD;
          hold_d  = bus.op_data;
        end
      end
      OP_HELD: begin
        fab_op_vld = 1'b1;
        op_ready   = bus.fab_op_ack;
        if (bus.fab_op_ack) begin
          if (bus.op_valid) hold_d  = bus.op_data;
          else              state_d = OP_EMPTY;
        end
      end
      default: state_d = OP_EMPTY;
    endcase
  end

  assign bus.op_ready   = op_ready;
  assign bus.fab_op_vld = fab_op_vld;

  logic [NUM_OP-1:0][LANE_W-1:0] op_in_l, op_hold_l, op_out_l;
  assign op_in_l   = bus.op_data;
  assign op_hold_l = hold_q;
  for (genvar i = 0; i < NUM_OP; i++) begin : g_op_lane
    assign op_out_l[i] = ConfigBits[i] ? op_hold_l[i] : op_in_l[i];
  end
  assign bus.fab_op = op_out_l;

  logic [RES_W-1:0] fifo_head;
  logic             res_valid, res_full, fifo_drop;
  logic [CNT_W-1:0] res_count;

  cpu_io_res_fifo #(.W(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk_i      (UserCLK),
    .rst_ni     (rst_n),
    .wr_req_i   (bus.fab_res_push),
    .wr_data_i  (bus.fab_res),
    .rd_ready_i (bus.res_ready),
    .rd_data_o  (fifo_head),
    .rd_valid_o (res_valid),
    .count_o    (res_count),
    .full_o     (res_full),
    .drop_o     (fifo_drop)
  );

  assign bus.res_valid = res_valid;
  assign bus.res_full  = res_full;
  assign bus.res_count = res_count;

  logic [NUM_RES-1:0][LANE_W-1:0] res_in_l, res_head_l, res_out_l;
  assign res_in_l   = bus.fab_res;
  assign res_head_l = fifo_head;
  for (genvar j = 0; j < NUM_RES; j++) begin : g_res_lane
    assign res_out_l[j] = ConfigBits[NUM_OP+j] ? res_head_l[j] : res_in_l[j];
  end
  assign bus.res_data = res_out_l;

`ifdef CPU_IO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  assign drop_cnt_d = fifo_drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = fifo_drop;
`endif

endmodule

// File: tb/tb_cpu_io_pass_n.sv
// Random + directed bench for cpu_io_pass_n with a queue-based reference model and scoreboard monitor.
module tb_cpu_io_pass_n;
  localparam int NOP = 2, NRES = 3, LW = 4, DEP = 4;
  localparam int OPW = NOP*LW, RW = NRES*LW;

  logic              UserCLK = 1'b0;
  logic              RESETn  = 1'b1;
  logic [NOP+NRES-1:0] cfg   = '1;
`ifdef CPU_IO_DROP_CNT_EN
  logic [7:0]        drop_cnt;
`endif

  cpu_io_pass_n_if #(.NUM_OP(NOP), .NUM_RES(NRES), .LANE_W(LW), .RES_DEPTH(DEP)) bus ();

  cpu_io_pass_n #(.NUM_OP(NOP), .NUM_RES(NRES), .LANE_W(LW), .RES_DEPTH(DEP)) dut (
    .UserCLK    (UserCLK),
    .RESETn     (RESETn),
    .ConfigBits (cfg),
`ifdef CPU_IO_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .bus        (bus)
  );

  always #5 UserCLK = ~UserCLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [OPW-1:0] op_mask(input logic [NOP+NRES-1:0] c);
    logic [OPW-1:0] m;
    m = '0;
    for (int i = 0; i < NOP; i++) if (c[i]) m[i*LW +: LW] = '1;
    return m;
  endfunction

  function automatic logic [RW-1:0] res_mask(input logic [NOP+NRES-1:0] c);
    logic [RW-1:0] m;
    m = '0;
    for (int j = 0; j < NRES; j++) if (c[NOP+j]) m[j*LW +: LW] = '1;
    return m;
  endfunction

  // Reference model: accepted operands awaiting the fabric, and result words awaiting the CPU.
  logic [OPW-1:0] op_q [$];
  logic [RW-1:0]  res_q [$];
  int             drops = 0;

  always @(negedge UserCLK) begin
    logic [OPW-1:0] om, ocare, oexp;
    logic [RW-1:0]  rm, rcare, rexp;
    logic           opr, popm, pushm;
    om = op_mask(cfg);
    rm = res_mask(cfg);
    if (!RESETn) begin
      op_q.delete();
      res_q.delete();
      drops = 0;
      chk("rst_op_ready",   32'(bus.op_ready),   32'd1);
      chk("rst_fab_op_vld", 32'(bus.fab_op_vld), 32'd0);
      chk("rst_res_valid",  32'(bus.res_valid),  32'd0);
      chk("rst_res_full",   32'(bus.res_full),   32'd0);
      chk("rst_res_count",  32'(bus.res_count),  32'd0);
      chk("rst_fab_op_reg_lanes", 32'(bus.fab_op & om),   32'd0);
      chk("rst_res_reg_lanes",    32'(bus.res_data & rm), 32'd0);
    end else begin
      opr   = (op_q.size() == 0) || bus.fab_op_ack;
      ocare = (op_q.size() != 0) ? '1 : ~om;
      oexp  = (((op_q.size() != 0) ? op_q[0] : '0) & om) | (bus.op_data & ~om);
      chk("fab_op_vld", 32'(bus.fab_op_vld), 32'(op_q.size() == 1));
      chk("op_ready",   32'(bus.op_ready),   32'(opr));
      chk("fab_op",     32'(bus.fab_op & ocare), 32'(oexp & ocare));

      rcare = (res_q.size() != 0) ? '1 : ~rm;
      rexp  = (((res_q.size() != 0) ? res_q[0] : '0) & rm) | (bus.fab_res & ~rm);
      chk("res_valid", 32'(bus.res_valid), 32'(res_q.size() != 0));
      chk("res_full",  32'(bus.res_full),  32'(res_q.size() == DEP));
      chk("res_count", 32'(bus.res_count), 32'(res_q.size()));
      chk("res_data",  32'(bus.res_data & rcare), 32'(rexp & rcare));
`ifdef CPU_IO_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(drops));
`endif
      if (op_q.size() != 0 && bus.fab_op_ack) void'(op_q.pop_front());
      if (bus.op_valid && opr) op_q.push_back(bus.op_data);
      popm  = (res_q.size() != 0) && bus.res_ready;
      pushm = bus.fab_res_push && ((res_q.size() < DEP) || popm);
      if (bus.fab_res_push && !pushm && drops < 255) drops++;
      if (popm)  void'(res_q.pop_front());
      if (pushm) res_q.push_back(bus.fab_res);
    end
  end

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic idle();
    bus.op_valid = 1'b0; bus.fab_op_ack = 1'b0;
    bus.fab_res_push = 1'b0; bus.res_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    RESETn = 1'b0;
    repeat (3) step();
    RESETn = 1'b1;
    repeat (4) step();
  endtask

  logic [OPW-1:0] t_op;
  logic [RW-1:0]  t_res;
  logic [RW-1:0]  exp34 [4];

  initial begin
    bus.op_data = '0; bus.fab_res = '0;
    idle();
    #1;
    do_reset();

    // Held operand stays on fab_op while the fabric stalls.
    bus.op_data = 8'h5A; bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0; bus.op_data = 8'hC3;
    for (int c = 0; c < 3; c++) begin
      @(negedge UserCLK);
      chk("stall_fab_op",   32'(bus.fab_op),     32'h5A);
      chk("stall_vld",      32'(bus.fab_op_vld), 32'd1);
      chk("stall_op_ready", 32'(bus.op_ready),   32'd0);
      step();
    end
    bus.fab_op_ack = 1'b1;
    @(negedge UserCLK);
    chk("ack_op_ready", 32'(bus.op_ready), 32'd1);
    step();
    bus.fab_op_ack = 1'b0;

    // Back-to-back: ack and a new operand in the same cycle.
    bus.op_data = 8'h11; bus.op_valid = 1'b1;
    step();
    bus.op_data = 8'h22; bus.fab_op_ack = 1'b1;
    @(negedge UserCLK);
    chk("b2b_old", 32'(bus.fab_op), 32'h11);
    step();
    bus.op_valid = 1'b0; bus.fab_op_ack = 1'b0;
    @(negedge UserCLK);
    chk("b2b_new", 32'(bus.fab_op),     32'h22);
    chk("b2b_vld", 32'(bus.fab_op_vld), 32'd1);
    step();
    bus.fab_op_ack = 1'b1;
    step();
    bus.fab_op_ack = 1'b0;

    // Overfill: fifth push is dropped.
    for (int k = 1; k <= 5; k++) begin
      bus.fab_res = 12'(k); bus.fab_res_push = 1'b1;
      @(negedge UserCLK);
      chk("fill_count", 32'(bus.res_count), (k - 1 < DEP) ? 32'(k - 1) : 32'(DEP));
      step();
    end
    bus.fab_res_push = 1'b0;
    @(negedge UserCLK);
    chk("fill_full",  32'(bus.res_full),  32'd1);
    chk("fill_count4", 32'(bus.res_count), 32'd4);
`ifdef CPU_IO_DROP_CNT_EN
    chk("fill_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    step();
    bus.res_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge UserCLK);
      chk("drain_data", 32'(bus.res_data), 32'(k));
      step();
    end
    bus.res_ready = 1'b0;

    // Push while full with a simultaneous pop.
    for (int k = 1; k <= 4; k++) begin
      bus.fab_res = 12'h100 + 12'(k); bus.fab_res_push = 1'b1;
      step();
    end
    bus.fab_res = 12'h0AB; bus.res_ready = 1'b1;
    step();
    bus.fab_res_push = 1'b0;
    exp34[0] = 12'h102; exp34[1] = 12'h103; exp34[2] = 12'h104; exp34[3] = 12'h0AB;
    for (int k = 0; k < 4; k++) begin
      @(negedge UserCLK);
      chk("fullpp_count", 32'(bus.res_count), 32'(4 - k));
      chk("fullpp_data",  32'(bus.res_data),  32'(exp34[k]));
      step();
    end
    bus.res_ready = 1'b0;

    // All-bypass: outputs follow inputs in the same cycle.
    cfg = '0;
    for (int k = 0; k < 3; k++) begin
      t_op = OPW'($urandom); t_res = RW'($urandom);
      bus.op_data = t_op; bus.fab_res = t_res;
      @(negedge UserCLK);
      chk("byp_fab_op",   32'(bus.fab_op),   32'(t_op));
      chk("byp_res_data", 32'(bus.res_data), 32'(t_res));
      step();
    end
    cfg = '1;

    // Reset mid-operation clears held operand and FIFO at once.
    bus.fab_res = 12'h3C1; bus.fab_res_push = 1'b1;
    bus.op_data = 8'h77;   bus.op_valid = 1'b1;
    step();
    bus.fab_res = 12'h3C2; bus.op_valid = 1'b0;
    step();
    idle();
    RESETn = 1'b0;
    #1;
    chk("midrst_res_valid", 32'(bus.res_valid),  32'd0);
    chk("midrst_res_count", 32'(bus.res_count),  32'd0);
    chk("midrst_fab_vld",   32'(bus.fab_op_vld), 32'd0);
    chk("midrst_op_ready",  32'(bus.op_ready),   32'd1);
    repeat (3) step();
    RESETn = 1'b1;
    repeat (4) step();

    // Random traffic, occasional config changes.
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) cfg = 5'($urandom);
      bus.op_data      = OPW'($urandom);
      bus.op_valid     = 1'($urandom);
      bus.fab_op_ack   = ($urandom_range(0, 2) != 0);
      bus.fab_res      = RW'($urandom);
      bus.fab_res_push = (c < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.res_ready    = (c < 750) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      step();
    end
    idle();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
